coef_bank_ctrl: RTL

//  Sequencer for the 9x32 one-hot-selected coefficient register bank in the LPC datapath.

---
 rtl/coef_bank_ctrl_pkg.sv | 19 +
 rtl/coef_idx_cnt.sv | 26 ++
 rtl/coef_bank_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/coef_bank_ctrl_pkg.sv
// Shared widths, state encodings and select helper for the coefficient bank sequencer.
package coef_bank_ctrl_pkg;

    localparam int unsigned N_REGS = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    // One-hot bank select for a word index (index is always 0..N_REGS-1 here).
    function automatic logic [N_REGS-1:0] onehot9(input logic [IDX_W-1:0] idx);
        return N_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/coef_idx_cnt.sv
// Word index counter 0..N_REGS-1 with increment, clear and terminal-count flag.
module coef_idx_cnt
    import coef_bank_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

    assign tc = (idx == LAST_IDX);

    // Count up; the step past the last word returns to 0 so the index never exceeds 8.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= tc ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/coef_bank_ctrl.sv
// Load/sweep sequencer for the 9x32 one-hot-selected LPC coefficient bank.
module coef_bank_ctrl
    import coef_bank_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              sweep_start,
    output logic [N_REGS-1:0] wsel,
    output logic [DATA_W-1:0] din,
    output logic [N_REGS-1:0] rsel,
    input  logic [DATA_W-1:0] rd_data,
    output logic              coef_valid,
    output logic [DATA_W-1:0] coef_data,
    output logic [IDX_W-1:0]  coef_idx,
    output logic              coef_last,
    output logic              bank_valid,
    output logic              busy
);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;
    logic             w_tc;
    logic             r_tc;
    logic             w_inc;
    logic             r_inc;
    logic             cnt_clr;
    logic             bv_set;
    logic             bv_clr;

    coef_idx_cnt u_widx (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (w_inc),
        .idx   (widx),
        .tc    (w_tc)
    );

    coef_idx_cnt u_ridx (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (r_inc),
        .idx   (ridx),
        .tc    (r_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame-resident flag: dropped on load entry or abort, raised by the word-8 write.
    always_ff @(posedge clk) begin
        if (reset || bv_clr) begin
            bank_valid <= 1'b0;
        end else if (bv_set) begin
            bank_valid <= 1'b1;
        end
    end

    // Next state and bank/stream/sweep outputs; clear overrides everything but reset.
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        wsel       = '0;
        din        = '0;
        rsel       = onehot9(IDX_W'(0));
        coef_valid = 1'b0;
        coef_data  = '0;
        coef_idx   = '0;
        coef_last  = 1'b0;
        w_inc      = 1'b0;
        r_inc      = 1'b0;
        cnt_clr    = 1'b0;
        bv_set     = 1'b0;
        bv_clr     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (sweep_start && bank_valid) begin
                    state_nxt = ST_SWEEP;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        // The entering handshake already writes word 0.
                        wsel      = onehot9(widx);
                        din       = s_data;
                        w_inc     = 1'b1;
                        bv_clr    = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wsel  = onehot9(widx);
                    din   = s_data;
                    w_inc = 1'b1;
                    if (w_tc) begin
                        bv_set    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_SWEEP: begin
                rsel       = onehot9(ridx);
                coef_valid = 1'b1;
                coef_data  = rd_data;
                coef_idx   = ridx;
                coef_last  = r_tc;
                r_inc      = 1'b1;
                if (r_tc) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (reset || clear) begin
            state_nxt = ST_IDLE;
            s_ready   = 1'b0;
            wsel      = '0;
            din       = '0;
            w_inc     = 1'b0;
            r_inc     = 1'b0;
            bv_set    = 1'b0;
            bv_clr    = 1'b1;
            cnt_clr   = 1'b1;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
